pipeline_hazard_unit: RTL and testbench

Parametrised hazard controller for the 5-stage pipelined processor. It generates register-forwarding selects for the EX stage, load-use stalls, and branch/jump flushes. It also freezes the whole pipeline while a multi-cycle data memory is busy. The block drives the per-stage enables and flushes of PC, IFID, IDEX, EXMEM and MEMWB, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_unit.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: EX forwarding selects, load-use stalls,
// branch/jump flushes, data-memory wait freeze and saturating stall/flush counters.
module pipeline_hazard_unit #(
    parameter int unsigned REG_W           = 5,
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned MEM_TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             branch_taken_id,
    input  logic             jump_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam int unsigned WAIT_W  = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [2:0]  LU_LOAD = 3'(LOAD_USE_CYCLES - 1);

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    state_t            eff_state;
    logic [2:0]        bubble_q, bubble_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              lu;
    logic              memwait;

    // MEM result has priority over WB; register 0 never forwards
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1))
            fwd_a = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
            fwd_a = 2'b01;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2))
            fwd_b = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
            fwd_b = 2'b01;
    end

    assign lu = ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Inside MEM_WAIT only dmem_ready releases the freeze
    assign memwait   = (state_q == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        bubble_d   = bubble_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (!enable) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (memwait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = MEM_WAIT;
            if (state_q != MEM_WAIT)
                saved_d = state_q;
            if (wait_q != '1)
                wait_d = wait_q + 1'b1;
            if ((MEM_TIMEOUT != 0) && (wait_d >= WAIT_W'(MEM_TIMEOUT)))
                timeout_d = 1'b1;
        end else begin
            wait_d  = '0;
            state_d = eff_state;
            if (jump_ex) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                bubble_d   = '0;
                state_d    = RUN;
            end else if (lu && (eff_state == RUN)) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                bubble_d   = LU_LOAD;
                state_d    = (LOAD_USE_CYCLES == 1) ? RUN : LU_STALL;
            end else if (eff_state == LU_STALL) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                bubble_d   = bubble_q - 1'b1;
                state_d    = (bubble_q <= 3'd1) ? RUN : LU_STALL;
            end else if (branch_taken_id) begin
                ifid_flush = 1'b1;
            end
        end

        if (enable) begin
            if (!pc_en && (stall_q != '1))
                stall_d = stall_q + 1'b1;
            if ((ifid_flush || idex_flush) && (flush_q != '1))
                flush_d = flush_q + 1'b1;
        end

        // Outputs show reset values for the whole time reset is held
        if (reset) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            saved_q   <= RUN;
            bubble_q  <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            bubble_q  <= bubble_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: instance a uses default parameters, instance b uses
// LOAD_USE_CYCLES=3, CNT_W=2, MEM_TIMEOUT=2; both share the same stimulus.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic       branch_taken_id, jump_ex, dmem_req, dmem_ready;

    logic [1:0]  a_fwd_a, a_fwd_b, a_state, b_fwd_a, b_fwd_b, b_state;
    logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en, a_ifid_flush, a_idex_flush, a_tmo;
    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en, b_ifid_flush, b_idex_flush, b_tmo;
    logic [15:0] a_stall, a_flush;
    logic [1:0]  b_stall, b_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.REG_W(5), .LOAD_USE_CYCLES(1), .CNT_W(16), .MEM_TIMEOUT(255)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken_id(branch_taken_id), .jump_ex(jump_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
        .exmem_en(a_exmem_en), .memwb_en(a_memwb_en), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .stall_cnt(a_stall), .flush_cnt(a_flush), .mem_timeout(a_tmo), .state(a_state)
    );

    pipeline_hazard_unit #(.REG_W(5), .LOAD_USE_CYCLES(3), .CNT_W(2), .MEM_TIMEOUT(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken_id(branch_taken_id), .jump_ex(jump_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .stall_cnt(b_stall), .flush_cnt(b_flush), .mem_timeout(b_tmo), .state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        enable = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
        branch_taken_id = 1'b0; jump_ex = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Called just after a falling edge: asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic set_lu();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3;
        id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        next_cycle();
        #1;
        chk("reset_state", a_state, 0);
        chk("reset_pc_en", a_pc_en, 1);
        chk("reset_counters", {a_stall, a_flush}, 0);
        chk("reset_timeout", a_tmo, 0);
        reset = 1'b0;

        // Forwarding
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
        #1 chk("fwd_mem_prio", a_fwd_a, 2'b10);
        mem_regwrite = 1'b0;
        #1 chk("fwd_wb", a_fwd_a, 2'b01);
        ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1;
        #1 chk("fwd_r0", a_fwd_a, 2'b00);
        ex_rs2 = 5'd7; wb_rd = 5'd7; mem_rd = 5'd6;
        #1 chk("fwd_b_wb", a_fwd_b, 2'b01);
        chk("fwd_a_none", a_fwd_a, 2'b00);

        // Load-use, single bubble (instance a)
        next_cycle(); pulse_reset();
        set_lu();
        #1;
        chk("lu1_pc_en", a_pc_en, 0);
        chk("lu1_ifid_en", a_ifid_en, 0);
        chk("lu1_idex_flush", a_idex_flush, 1);
        chk("lu1_idex_en", a_idex_en, 1);
        next_cycle();
        ex_memread = 1'b0;
        #1;
        chk("lu1_state_run", a_state, 0);
        chk("lu1_pc_en_after", a_pc_en, 1);
        chk("lu1_stall_cnt", a_stall, 1);
        chk("lu1_flush_cnt", a_flush, 1);

        // Load-use, three bubbles, jump in second stall cycle (instance b)
        next_cycle(); pulse_reset();
        set_lu();
        #1 chk("lu3_c1_pc_en", b_pc_en, 0);
        next_cycle();
        ex_memread = 1'b0; jump_ex = 1'b1;
        #1;
        chk("lu3_c2_state", b_state, 2'b01);
        chk("lu3_jump_flushes", {b_ifid_flush, b_idex_flush}, 2'b11);
        chk("lu3_jump_enables", {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en}, 5'b11111);
        next_cycle();
        jump_ex = 1'b0;
        #1;
        chk("lu3_jump_state", b_state, 0);
        chk("lu3_jump_pc_en", b_pc_en, 1);
        chk("lu3_jump_stall_cnt", b_stall, 1);
        chk("lu3_jump_flush_cnt", b_flush, 2);

        // Memory wait: 4 wait cycles then ready, plus a 5th stall for saturation
        next_cycle(); pulse_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1 chk("mw_c1_enables", {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en}, 0);
        next_cycle();
        #1;
        chk("mw_c2_state", a_state, 2'b10);
        chk("mw_c2_timeout_low", b_tmo, 0);
        chk("mw_c2_enables", {a_pc_en, a_memwb_en}, 0);
        next_cycle();
        #1 chk("mw_c3_timeout_high", b_tmo, 1);
        next_cycle();
        #1 chk("mw_c4_state", a_state, 2'b10);
        next_cycle();
        dmem_ready = 1'b1;
        #1;
        chk("mw_resume_state", a_state, 2'b10);
        chk("mw_resume_enables", {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en}, 5'b11111);
        next_cycle();
        dmem_req = 1'b0;
        #1;
        chk("mw_back_run", a_state, 0);
        chk("mw_stall_cnt", a_stall, 4);
        chk("mw_timeout_sticky", b_tmo, 1);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        next_cycle();
        dmem_req = 1'b0; dmem_ready = 1'b1;
        next_cycle();
        #1;
        chk("sat_stall_a", a_stall, 5);
        chk("sat_stall_b", b_stall, 3);
        chk("sat_timeout_sticky", b_tmo, 1);

        // Memory wait during LU_STALL resumes the stall (instance b)
        next_cycle(); pulse_reset();
        set_lu();
        next_cycle();
        ex_memread = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
        #1 chk("lumw_freeze_flush", b_idex_flush, 0);
        next_cycle();
        dmem_ready = 1'b1;
        #1;
        chk("lumw_resume_state", b_state, 2'b10);
        chk("lumw_resume_stall", {b_pc_en, b_idex_flush}, 2'b01);
        next_cycle();
        dmem_req = 1'b0;
        #1;
        chk("lumw_back_lu", b_state, 2'b01);
        chk("lumw_last_bubble", b_pc_en, 0);
        next_cycle();
        #1 chk("lumw_run", {b_state, b_pc_en}, 3'b001);

        // Branch in ID
        next_cycle(); pulse_reset();
        branch_taken_id = 1'b1;
        #1 chk("br_flush", {a_ifid_flush, a_idex_flush, a_pc_en}, 3'b101);
        next_cycle();
        branch_taken_id = 1'b0;
        #1;
        chk("br_flush_cnt", a_flush, 1);
        chk("br_flush_gone", a_ifid_flush, 0);
        branch_taken_id = 1'b1; set_lu();
        #1 chk("br_lu_suppressed", {a_ifid_flush, a_idex_flush, a_pc_en}, 3'b010);

        // Global enable low freezes everything but forwarding
        next_cycle(); pulse_reset();
        set_lu(); enable = 1'b0; ex_rs1 = 5'd4; mem_rd = 5'd4; mem_regwrite = 1'b1;
        #1;
        chk("en0_stage_enables", {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en}, 0);
        chk("en0_flushes", {a_ifid_flush, a_idex_flush}, 0);
        chk("en0_fwd", a_fwd_a, 2'b10);
        next_cycle();
        #1 chk("en0_frozen", {b_state, a_stall, a_flush}, 0);

        // Asynchronous reset mid LU_STALL
        next_cycle(); pulse_reset();
        set_lu();
        next_cycle();
        #1 chk("ar_in_stall", b_state, 2'b01);
        reset = 1'b1;
        #1;
        chk("ar_state", b_state, 0);
        chk("ar_counters", {b_stall, b_flush}, 0);
        chk("ar_enables", {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en}, 5'b11111);
        chk("ar_flushes", {b_ifid_flush, b_idex_flush}, 0);
        clear_inputs();
        reset = 1'b0;
        next_cycle();
        #1 chk("ar_no_bubble", {b_state, b_pc_en}, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
